// File: rtl/serial_subtractor_pkg.sv
// Shared arithmetic package: FSM state encoding, default width and a
// constant-function helper for sizing counters.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int SUB_WIDTH_DEFAULT = 8;

    // Ceiling log2, never smaller than 1 so a counter always has a bit.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/ready/done handshake plus operand and result buses for the
// bit-serial subtractor. The controller side uses the master modport.
interface serial_subtractor_if
    import arith_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             zero;

    modport master (
        output start, a, b,
        input  ready, done, diff, borrow_out, zero
    );

    modport slave (
        input  start, a, b,
        output ready, done, diff, borrow_out, zero
    );

endinterface

// File: rtl/serial_subtractor_bit.sv
// One-bit full subtractor cell: d = x - y - bin with borrow out.
module full_subtractor_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference and borrow for a single bit position.
    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b LSB first through a single
// full-subtractor cell, one bit per clock, with the borrow kept in a flop.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);

    localparam int CNT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sub_state_t       state;
    sub_state_t       state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [CNT_W-1:0] bit_cnt;
    logic             bin_q;
    logic             d_bit;
    logic             bout_bit;
    logic             last_bit;

    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             zero_q;

    full_subtractor_bit u_cell (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (bin_q),
        .d    (d_bit),
        .bout (bout_bit)
    );

    // The result fills from the MSB end so after WIDTH shifts bit 0 is at the LSB.
    always_comb begin
        res_next = {d_bit, res_sr[WIDTH-1:1]};
        last_bit = (state == RUN) && (bit_cnt == LAST_BIT);
    end

    // State register; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept only from IDLE, DONE lasts exactly one cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (bus.start) state_next = RUN;
            RUN:  if (last_bit)  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand/result shifting, borrow flop, bit counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            bit_cnt  <= '0;
            bin_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr    <= bus.a;
                        b_sr    <= bus.b;
                        res_sr  <= '0;
                        bit_cnt <= '0;
                        bin_q   <= 1'b0;
                    end
                end
                RUN: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    res_sr  <= res_next;
                    bin_q   <= bout_bit;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (last_bit) begin
                        diff_q   <= res_next;
                        borrow_q <= bout_bit;
                        zero_q   <= ~|res_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake flags decode straight from the registered state.
    always_comb begin
        bus.ready      = (state == IDLE);
        bus.done       = (state == DONE);
        bus.diff       = diff_q;
        bus.borrow_out = borrow_q;
        bus.zero       = zero_q;
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: an 8-bit and a 16-bit instance,
// expected results queued at issue time and compared when done pulses.
module tb_serial_subtractor;

    typedef struct {
        logic [31:0] diff;
        logic        borrow;
        logic        zero;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;

    exp_t q8[$];
    exp_t q16[$];

    int   done8Count;
    int   lastDone8;
    int   prevDone8;
    logic prevDone8Lvl;
    logic prevDone16Lvl;

    serial_subtractor_if #(.WIDTH(8))  bus8  ();
    serial_subtractor_if #(.WIDTH(16)) bus16 ();

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16.slave)
    );

    // 10-time-unit clock and an edge counter used for latency checks.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case something wedges beyond every per-wait bound.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     tag, observed, expected, cyc);
        end
    endtask

    // Scoreboard check for the 8-bit instance.
    always @(negedge clk) begin : mon8
        exp_t e;
        if (!rst && bus8.done) begin
            checkOutput("done8_width", {31'd0, prevDone8Lvl}, 32'd0);
            done8Count++;
            prevDone8 = lastDone8;
            lastDone8 = cyc;
            if (q8.size() == 0) begin
                checkOutput("done8_spurious", 32'd1, 32'd0);
            end else begin
                e = q8.pop_front();
                checkOutput("diff8",    {24'd0, bus8.diff}, e.diff);
                checkOutput("borrow8",  {31'd0, bus8.borrow_out}, {31'd0, e.borrow});
                checkOutput("zero8",    {31'd0, bus8.zero}, {31'd0, e.zero});
                checkOutput("latency8", cyc - e.cyc, 32'd8);
            end
        end
        prevDone8Lvl = bus8.done;
    end

    // Scoreboard check for the 16-bit instance.
    always @(negedge clk) begin : mon16
        exp_t e;
        if (!rst && bus16.done) begin
            checkOutput("done16_width", {31'd0, prevDone16Lvl}, 32'd0);
            if (q16.size() == 0) begin
                checkOutput("done16_spurious", 32'd1, 32'd0);
            end else begin
                e = q16.pop_front();
                checkOutput("diff16",    {16'd0, bus16.diff}, e.diff);
                checkOutput("borrow16",  {31'd0, bus16.borrow_out}, {31'd0, e.borrow});
                checkOutput("zero16",    {31'd0, bus16.zero}, {31'd0, e.zero});
                checkOutput("latency16", cyc - e.cyc, 32'd16);
            end
        end
        prevDone16Lvl = bus16.done;
    end

    // Wait for the chosen instance to be ready, then issue one operation.
    task automatic applyStimulus(input bit wide, input logic [31:0] av,
                                 input logic [31:0] bv);
        exp_t        e;
        logic [31:0] mask;
        int          guard;
        mask  = wide ? 32'h0000_FFFF : 32'h0000_00FF;
        guard = 0;
        while (!(wide ? bus16.ready : bus8.ready) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("ready_wait", {31'd0, (wide ? bus16.ready : bus8.ready)}, 32'd1);
        e.diff   = (av - bv) & mask;
        e.borrow = (av & mask) < (bv & mask);
        e.zero   = (e.diff == 32'd0);
        if (wide) begin
            bus16.start = 1'b1;
            bus16.a     = av[15:0];
            bus16.b     = bv[15:0];
        end else begin
            bus8.start = 1'b1;
            bus8.a     = av[7:0];
            bus8.b     = bv[7:0];
        end
        @(posedge clk); #1;
        e.cyc = cyc;
        if (wide) q16.push_back(e);
        else      q8.push_back(e);
        bus16.start = 1'b0;
        bus8.start  = 1'b0;
        bus8.a      = 8'hA5;
        bus8.b      = 8'h3C;
    endtask

    // Let the outstanding work drain and the instance return to idle.
    task automatic waitIdle(input bit wide);
        int guard;
        guard = 0;
        while (((wide ? q16.size() : q8.size()) != 0 ||
                !(wide ? bus16.ready : bus8.ready)) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("drain", wide ? q16.size() : q8.size(), 32'd0);
    endtask

    initial begin
        int doneBefore;
        cyc = 0; checks = 0; failures = 0;
        done8Count = 0; lastDone8 = 0; prevDone8 = 0;
        prevDone8Lvl = 1'b0; prevDone16Lvl = 1'b0;
        rst = 1'b1;
        bus8.start = 1'b0;  bus8.a = '0;  bus8.b = '0;
        bus16.start = 1'b0; bus16.a = '0; bus16.b = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready",  {31'd0, bus8.ready}, 32'd1);
        checkOutput("rst_done",   {31'd0, bus8.done}, 32'd0);
        checkOutput("rst_diff",   {24'd0, bus8.diff}, 32'd0);
        checkOutput("rst_borrow", {31'd0, bus8.borrow_out}, 32'd0);
        checkOutput("rst_zero",   {31'd0, bus8.zero}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] basic subtractions");
        applyStimulus(0, 32'h05, 32'h03); waitIdle(0);
        applyStimulus(0, 32'h03, 32'h05); waitIdle(0);
        applyStimulus(0, 32'h00, 32'hFF); waitIdle(0);
        applyStimulus(0, 32'h5A, 32'h5A); waitIdle(0);

        repeat (20) @(posedge clk);
        #1;
        checkOutput("hold_diff",   {24'd0, bus8.diff}, 32'h00);
        checkOutput("hold_borrow", {31'd0, bus8.borrow_out}, 32'd0);
        checkOutput("hold_zero",   {31'd0, bus8.zero}, 32'd1);

        $display("[TB] start ignored while busy");
        doneBefore = done8Count;
        applyStimulus(0, 32'h80, 32'h01);
        for (int i = 0; i < 8; i++) begin
            checkOutput("run_ready", {31'd0, bus8.ready}, 32'd0);
            if (i == 3) begin
                bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF;
            end
            if (i == 4) bus8.start = 1'b0;
            @(posedge clk); #1;
        end
        waitIdle(0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("busy_done_count", done8Count - doneBefore, 32'd1);
        checkOutput("busy_diff", {24'd0, bus8.diff}, 32'h7F);

        $display("[TB] reset mid-run");
        applyStimulus(0, 32'h40, 32'h11);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        bus8.start = 1'b1; bus8.a = 8'h22; bus8.b = 8'h01;
        @(posedge clk); #1;
        rst = 1'b0;
        bus8.start = 1'b0;
        void'(q8.pop_back());
        checkOutput("abort_ready",  {31'd0, bus8.ready}, 32'd1);
        checkOutput("abort_done",   {31'd0, bus8.done}, 32'd0);
        checkOutput("abort_diff",   {24'd0, bus8.diff}, 32'd0);
        checkOutput("abort_borrow", {31'd0, bus8.borrow_out}, 32'd0);
        doneBefore = done8Count;
        repeat (12) begin
            @(posedge clk); #1;
        end
        checkOutput("abort_no_done", done8Count - doneBefore, 32'd0);
        checkOutput("abort_idle",    {31'd0, bus8.ready}, 32'd1);

        $display("[TB] back-to-back");
        applyStimulus(0, 32'h10, 32'h01);
        applyStimulus(0, 32'h01, 32'h10);
        waitIdle(0);
        checkOutput("b2b_gap", lastDone8 - prevDone8, 32'd10);

        $display("[TB] 16-bit instance");
        applyStimulus(1, 32'h0000, 32'h0001); waitIdle(1);
        applyStimulus(1, 32'h1234, 32'h0234); waitIdle(1);
        applyStimulus(1, 32'hBEEF, 32'hBEEF); waitIdle(1);

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
